// File: rtl/func_rate1_spc_seq.sv
// Sequential Rate-1 / SPC node processor for the fast-SSC polar decoder.
// Collects a node as P-LLR beats, takes hard decisions, and for SPC nodes
// flips the least-reliable bit when the overall parity is odd. Bits are
// then streamed back out as P-bit beats.

// Per-lane hard decision and magnitude of one LLR.
module func_rate1_spc_seq_lane #(
    parameter int LLR_W = 6
) (
    input  logic [LLR_W-1:0] llr,
    output logic             hd,
    output logic [LLR_W-1:0] mag
);
    assign hd  = llr[LLR_W-1];
    // Unsigned result keeps |-2^(LLR_W-1)| = 2^(LLR_W-1) without saturating.
    assign mag = hd ? (-llr) : llr;
endmodule

module func_rate1_spc_seq #(
    parameter int LLR_W     = 6,
    parameter int P         = 16,
    parameter int MAX_BEATS = 4,
    localparam int NBW      = $clog2(MAX_BEATS) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic [NBW-1:0]     node_beats,
    input  logic               llr_valid,
    output logic               llr_ready,
    input  logic [P*LLR_W-1:0] llr,
    output logic               bit_valid,
    input  logic               bit_ready,
    output logic [P-1:0]       bit_out,
    output logic               busy,
    output logic               done
);
    localparam int BIW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int KW  = (P > 1) ? $clog2(P) : 1;
    localparam logic [NBW-1:0] MAXB = NBW'(MAX_BEATS);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FIX, S_OUTPUT} state_t;

    state_t state_q, state_d;

    logic                          mode_q;
    logic [BIW-1:0]                last_q;
    logic [BIW-1:0]                in_cnt, out_cnt;
    logic                          parity_q;
    logic [LLR_W-1:0]              min_mag;
    logic [BIW-1:0]                min_beat;
    logic [KW-1:0]                 min_pos;   // bit position inside the beat (P-1-k)
    logic [MAX_BEATS-1:0][P-1:0]   buf_q;
    logic                          done_q;

    // Lane outputs; hd_bits is already in bit_out ordering.
    logic [P-1:0]            hd_bits;
    logic [P-1:0][LLR_W-1:0] mag;

    genvar k;
    generate
        for (k = 0; k < P; k++) begin : g_lane
            func_rate1_spc_seq_lane #(.LLR_W(LLR_W)) u_lane (
                .llr (llr[(P-k)*LLR_W-1 -: LLR_W]),
                .hd  (hd_bits[P-1-k]),
                .mag (mag[k])
            );
        end
    endgenerate

    logic             in_hs, out_hs, in_last, out_last;
    logic [LLR_W-1:0] bmin;
    logic [KW-1:0]    bpos;
    logic [NBW-1:0]   nb_eff;
    logic [BIW-1:0]   start_last;

    assign llr_ready = (state_q == S_COLLECT);
    assign bit_valid = (state_q == S_OUTPUT);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign bit_out   = bit_valid ? buf_q[out_cnt] : '0;

    assign in_hs    = llr_valid && llr_ready;
    assign out_hs   = bit_valid && bit_ready;
    assign in_last  = (in_cnt == last_q);
    assign out_last = (out_cnt == last_q);

    // Clamp the requested length and turn it into the index of the last beat.
    always_comb begin
        nb_eff = node_beats;
        if (node_beats == '0 || node_beats > MAXB) nb_eff = MAXB;
        start_last = BIW'(nb_eff - NBW'(1));
    end

    // Beat-local minimum; strict compare keeps the lowest lane on ties.
    always_comb begin
        bmin = mag[0];
        bpos = KW'(P-1);
        for (int i = 1; i < P; i++) begin
            if (mag[i] < bmin) begin
                bmin = mag[i];
                bpos = KW'(P-1-i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_COLLECT;
            S_COLLECT: if (in_hs && in_last) state_d = mode_q ? S_FIX : S_OUTPUT;
            S_FIX:     state_d = S_OUTPUT;
            S_OUTPUT:  if (out_hs && out_last) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath: node setup, beat capture, parity/min tracking, SPC fix, output count.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= 1'b0;
            last_q   <= '0;
            in_cnt   <= '0;
            out_cnt  <= '0;
            parity_q <= 1'b0;
            min_mag  <= '1;
            min_beat <= '0;
            min_pos  <= '0;
            buf_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= out_hs && out_last;
            case (state_q)
                S_IDLE: if (start) begin
                    mode_q   <= mode;
                    last_q   <= start_last;
                    in_cnt   <= '0;
                    out_cnt  <= '0;
                    parity_q <= 1'b0;
                    min_mag  <= '1;
                    min_beat <= '0;
                    min_pos  <= '0;
                end
                S_COLLECT: if (in_hs) begin
                    buf_q[in_cnt] <= hd_bits;
                    parity_q      <= parity_q ^ (^hd_bits);
                    // Earlier beats hold lower global indices, so strict < resolves ties.
                    if (bmin < min_mag) begin
                        min_mag  <= bmin;
                        min_beat <= in_cnt;
                        min_pos  <= bpos;
                    end
                    in_cnt <= in_cnt + BIW'(1);
                end
                S_FIX: if (parity_q) begin
                    buf_q[min_beat][min_pos] <= ~buf_q[min_beat][min_pos];
                end
                S_OUTPUT: if (out_hs) begin
                    out_cnt <= out_cnt + BIW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_func_rate1_spc_seq.sv
// Directed bench for func_rate1_spc_seq: hand-computed beats, latency,
// backpressure, tie-break, extreme LLR, length clamp and mid-node reset.
module tb_func_rate1_spc_seq;
    localparam int LLR_W = 6;
    localparam int P     = 16;
    localparam int NBW   = 3;

    logic               clk = 1'b0;
    logic               rst, start, mode;
    logic [NBW-1:0]     node_beats;
    logic               llr_valid, llr_ready;
    logic [P*LLR_W-1:0] llr;
    logic               bit_valid, bit_ready;
    logic [P-1:0]       bit_out;
    logic               busy, done;

    int n_chk = 0;
    int n_err = 0;

    logic [LLR_W-1:0] el [64];
    logic [P-1:0]     exp_b [4];

    always #5 clk = ~clk;

    func_rate1_spc_seq dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .node_beats(node_beats),
        .llr_valid(llr_valid), .llr_ready(llr_ready), .llr(llr),
        .bit_valid(bit_valid), .bit_ready(bit_ready), .bit_out(bit_out),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [P*LLR_W-1:0] beat(input int b);
        logic [P*LLR_W-1:0] v;
        for (int k = 0; k < P; k++) v[(P-k)*LLR_W-1 -: LLR_W] = el[b*P+k];
        return v;
    endfunction

    task automatic fill(input logic [LLR_W-1:0] v);
        for (int i = 0; i < 64; i++) el[i] = v;
    endtask

    task automatic set_exp(input logic [P-1:0] e0, e1, e2, e3);
        exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2; exp_b[3] = e3;
    endtask

    // Run one node; stall_beat >= 0 holds bit_ready low for 5 cycles on that beat.
    task automatic run_node(input string tag, input logic m, input logic [NBW-1:0] nbf,
                            input int nb, input int stall_beat);
        @(negedge clk);
        start = 1'b1; mode = m; node_beats = nbf;
        @(negedge clk);
        start = 1'b0; mode = 1'b0;
        for (int b = 0; b < nb; b++) begin
            llr_valid = 1'b1;
            llr = beat(b);
            check({tag, "/llr_ready"}, 32'(llr_ready), 32'd1);
            @(negedge clk);
        end
        llr_valid = 1'b0;
        llr = '0;
        check({tag, "/ready_drop"}, 32'(llr_ready), 32'd0);
        check({tag, "/lat_t1"}, 32'(bit_valid), m ? 32'd0 : 32'd1);
        if (m) begin
            @(negedge clk);
            check({tag, "/lat_t2"}, 32'(bit_valid), 32'd1);
        end
        for (int o = 0; o < nb; o++) begin
            if (o == stall_beat) begin
                bit_ready = 1'b0;
                start     = 1'b1;     // must be ignored outside IDLE
                llr_valid = 1'b1;     // must be ignored outside COLLECT
                repeat (5) begin
                    check({tag, "/stall_out"}, 32'(bit_out), 32'(exp_b[o]));
                    check({tag, "/stall_vld"}, 32'(bit_valid), 32'd1);
                    check({tag, "/stall_done"}, 32'(done), 32'd0);
                    check({tag, "/stall_llr_ready"}, 32'(llr_ready), 32'd0);
                    @(negedge clk);
                end
                start     = 1'b0;
                llr_valid = 1'b0;
            end
            bit_ready = 1'b1;
            check({tag, $sformatf("/vld%0d", o)}, 32'(bit_valid), 32'd1);
            check({tag, $sformatf("/beat%0d", o)}, 32'(bit_out), 32'(exp_b[o]));
            @(negedge clk);
        end
        bit_ready = 1'b0;
        check({tag, "/done"}, 32'(done), 32'd1);
        check({tag, "/vld_end"}, 32'(bit_valid), 32'd0);
        check({tag, "/busy_end"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "/done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; node_beats = '0;
        llr_valid = 1'b0; llr = '0; bit_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst/llr_ready", 32'(llr_ready), 32'd0);
        check("rst/bit_valid", 32'(bit_valid), 32'd0);
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/done", 32'(done), 32'd0);
        check("rst/bit_out", 32'(bit_out), 32'd0);

        // Rate-1, alternating +5/-5, elem0 = +5.
        for (int i = 0; i < 64; i++) el[i] = i[0] ? 6'h3B : 6'h05;
        set_exp(16'h5555, 16'h0, 16'h0, 16'h0);
        run_node("r1_alt", 1'b0, 3'd1, 1, -1);

        // SPC single beat, odd parity, elem4 is least reliable.
        fill(6'h03); el[4] = 6'h3F;
        set_exp(16'h0000, 16'h0, 16'h0, 16'h0);
        run_node("spc_flip4", 1'b1, 3'd1, 1, -1);

        // SPC 4 beats, min at elem37, elem50 negative.
        fill(6'h07); el[37] = 6'h02; el[50] = 6'h3A;
        set_exp(16'h0000, 16'h0000, 16'h0400, 16'h2000);
        run_node("spc_flip37", 1'b1, 3'd4, 4, -1);

        // Tie: elem10 also +2, lower index wins.
        el[10] = 6'h02;
        set_exp(16'h0020, 16'h0000, 16'h0000, 16'h2000);
        run_node("spc_tie10", 1'b1, 3'd4, 4, -1);

        // SPC even parity with backpressure on beat 1.
        fill(6'h04); el[3] = 6'h3E; el[20] = 6'h3B;
        set_exp(16'h1000, 16'h0800, 16'h0, 16'h0);
        run_node("spc_even_bp", 1'b1, 3'd2, 2, 1);

        // Extreme: fifteen -32 and one +31; min must be +31 (|-32| = 32).
        fill(6'h20); el[7] = 6'h1F;
        set_exp(16'hFFFF, 16'h0, 16'h0, 16'h0);
        run_node("spc_extreme", 1'b1, 3'd1, 1, -1);

        // node_beats = 0 runs as 4 beats.
        fill(6'h01);
        for (int b = 0; b < 4; b++) el[b*P+b] = 6'h3F;
        set_exp(16'h8000, 16'h4000, 16'h2000, 16'h1000);
        run_node("r1_nb0", 1'b0, 3'd0, 4, -1);

        // node_beats above the maximum is clamped to 4 as well.
        run_node("r1_nb7", 1'b0, 3'd7, 4, -1);

        // Reset during COLLECT aborts the node.
        @(negedge clk);
        start = 1'b1; mode = 1'b1; node_beats = 3'd4;
        @(negedge clk);
        start = 1'b0;
        llr_valid = 1'b1; llr = beat(0);
        @(negedge clk);
        llr = beat(1);
        @(negedge clk);
        llr_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort/busy", 32'(busy), 32'd0);
        check("abort/llr_ready", 32'(llr_ready), 32'd0);
        check("abort/bit_valid", 32'(bit_valid), 32'd0);
        check("abort/done", 32'(done), 32'd0);
        check("abort/bit_out", 32'(bit_out), 32'd0);
        repeat (3) @(negedge clk);
        check("abort/quiet_valid", 32'(bit_valid), 32'd0);

        // A fresh node after the abort behaves normally.
        for (int i = 0; i < 64; i++) el[i] = i[0] ? 6'h3B : 6'h05;
        set_exp(16'h5555, 16'h0, 16'h0, 16'h0);
        run_node("r1_after_rst", 1'b0, 3'd1, 1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
